// File: rtl/ddr3_iod_ctrl_pkg.sv
// Shared types and constants for the DDR3 IOD output delay-line sequencer.
package ddr3_iod_ctrl_pkg;

    // Command opcodes as carried on CMD_OP.
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD,
        ST_DIR_SETUP,
        ST_MOVE,
        ST_SETTLE,
        ST_DONE,
        ST_IDLE
    } state_t;

    // Idle cycles after each MOVE pulse unless overridden (legal 1..15).
    localparam int unsigned DEF_SETTLE_CYCLES = 4;

    // Width of the settle timer; covers the full 1..15 settle range.
    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/ddr3_iod_step_timer.sv
// Loadable down-counter with a terminal-count flag; spaces MOVE pulses.
module ddr3_iod_step_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;

    // Count down from the loaded value and park at zero.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/ddr3_iod_delay_ctrl.sv
// Sequencer for one DDR3 PHY output IOD dynamic delay line: load/inc/dec
// commands in, spaced LOAD/MOVE/DIRECTION strobes out, tap position tracked.
module ddr3_iod_delay_ctrl
    import ddr3_iod_ctrl_pkg::*;
#(
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned TAP_INIT      = 1,
    parameter int unsigned MAX_TAP       = 255,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [TAP_W-1:0] CMD_STEPS,
    output logic             DONE,
    output logic             BUSY,
    output logic [TAP_W-1:0] TAP_POS,
    output logic             ERR_OOR,
    input  logic             ERR_CLR,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [TAP_W-1:0]    TAP_INIT_V   = TAP_W'(TAP_INIT);
    localparam logic [TAP_W-1:0]    MAX_TAP_V    = TAP_W'(MAX_TAP);
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_next;
    op_t               op;
    logic              accept;
    logic              cmd_is_move;
    logic              at_bound;
    logic              move_ok;
    logic              set_err;
    logic              settle_tc;
    logic              dir_q;
    logic              err_q;
    logic              pwr_up_q;
    logic [TAP_W-1:0]  tap_q;
    logic [TAP_W-1:0]  remaining_q;

    assign op          = op_t'(CMD_OP);
    assign accept      = CMD_VALID && (state_q == ST_IDLE);
    assign cmd_is_move = ((op == OP_INC) || (op == OP_DEC)) && (CMD_STEPS != '0);
    // A step that would leave the legal window is refused before it is issued.
    assign at_bound    = dir_q ? (tap_q == MAX_TAP_V) : (tap_q == '0);
    assign move_ok     = (state_q == ST_MOVE) && !at_bound;

    // Settle spacing: reloaded on every issued MOVE, flags the last SETTLE cycle.
    ddr3_iod_step_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .clk      (FAB_CLK),
        .rst_n    (ARST_N),
        .load     (move_ok),
        .load_val (SETTLE_RELOAD),
        .tc       (settle_tc)
    );

    // Next-state and abort decision.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state_q;
        set_err    = 1'b0;
        case (state_q)
            ST_INIT:      state_next = ST_LOAD;
            ST_LOAD:      state_next = pwr_up_q ? ST_IDLE : ST_DONE;
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_LOAD)    state_next = ST_LOAD;
                    else if (cmd_is_move) state_next = ST_DIR_SETUP;
                    else                  state_next = ST_DONE;
                end
            end
            ST_DIR_SETUP: state_next = ST_MOVE;
            ST_MOVE: begin
                if (at_bound) begin
                    set_err    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_tc) begin
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        set_err    = 1'b1;
                        state_next = ST_DONE;
                    end else if (remaining_q == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_MOVE;
                    end
                end
            end
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_INIT;
        endcase
    end

    // State register and registered (glitch-free) strobes/status decoded from the next state.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q         <= ST_INIT;
            DELAY_LINE_LOAD <= 1'b0;
            DELAY_LINE_MOVE <= 1'b0;
            DONE            <= 1'b0;
            BUSY            <= 1'b1;
            CMD_READY       <= 1'b0;
        end else begin
            state_q         <= state_next;
            DELAY_LINE_LOAD <= (state_next == ST_LOAD);
            DELAY_LINE_MOVE <= (state_next == ST_MOVE) && !at_bound;
            DONE            <= (state_next == ST_DONE);
            BUSY            <= (state_next != ST_IDLE);
            CMD_READY       <= (state_next == ST_IDLE);
        end
    end

    // Command capture, step counting, tap tracking and the sticky error flag.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            dir_q       <= 1'b0;
            remaining_q <= '0;
            tap_q       <= TAP_INIT_V;
            err_q       <= 1'b0;
            pwr_up_q    <= 1'b1;
        end else begin
            if (accept && cmd_is_move) begin
                dir_q       <= (op == OP_INC);
                remaining_q <= CMD_STEPS;
            end else if (move_ok) begin
                remaining_q <= remaining_q - TAP_W'(1);
            end

            if (state_q == ST_LOAD) begin
                tap_q <= TAP_INIT_V;
            end else if (move_ok) begin
                tap_q <= dir_q ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
            end

            // A new error outranks a simultaneous clear request.
            if (set_err) begin
                err_q <= 1'b1;
            end else if ((state_q == ST_LOAD) || ERR_CLR) begin
                err_q <= 1'b0;
            end

            if (state_q == ST_LOAD) begin
                pwr_up_q <= 1'b0;
            end
        end
    end

    assign TAP_POS              = tap_q;
    assign ERR_OOR              = err_q;
    assign DELAY_LINE_DIRECTION = dir_q;

endmodule
